// File: rtl/rv32_isa.sv
// Shared RV32 ISA package: register width, M-extension funct3/funct7 encodings
// and the multiply/divide unit state type.
package rv32_isa;

   localparam int RegWidth = 32;

   localparam logic [2:0] OpF3MUL    = 3'b000;
   localparam logic [2:0] OpF3MULH   = 3'b001;
   localparam logic [2:0] OpF3MULHSU = 3'b010;
   localparam logic [2:0] OpF3MULHU  = 3'b011;
   localparam logic [2:0] OpF3DIV    = 3'b100;
   localparam logic [2:0] OpF3DIVU   = 3'b101;
   localparam logic [2:0] OpF3REM    = 3'b110;
   localparam logic [2:0] OpF3REMU   = 3'b111;

   localparam logic [6:0] OpF7MUL    = 7'b0000001;

   localparam int MdIterCount = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } MdState_t;

endpackage

// File: rtl/rv32_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module rv32_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] quo_i,
   input  logic [W-1:0] div_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] quo_o
);

   logic [W:0] shifted;
   logic       ge;

   // The dividend is consumed MSB-first out of the quotient register.
   assign shifted = {rem_i, quo_i[W-1]};
   assign ge      = shifted >= {1'b0, div_i};
   assign rem_o   = ge ? W'(shifted - {1'b0, div_i}) : shifted[W-1:0];
   assign quo_o   = {quo_i[W-2:0], ge};

endmodule

// File: rtl/rv32_muldiv.sv
// RV32M multiply/divide/remainder execute unit, 32-cycle iterative datapath.
// Optional macro RV32_MULDIV_FASTMUL_EN: single-cycle combinational multiplies.
//
// state | meaning
// IDLE  | ready for an op; special cases resolve straight to DONE
// CALC  | one shift-add / shift-subtract iteration per cycle, cnt 0..31
// DONE  | result valid and held until o_ready
module rv32_muldiv
   import rv32_isa::*;
#(
   parameter int XLEN = RegWidth
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            i_valid,
   output logic            i_ready,
   input  logic [2:0]      i_f3,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [4:0]      i_rd,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            o_ready,
   output logic [XLEN-1:0] o_result,
   output logic [4:0]      o_rd,
   output logic            o_busy
);

   MdState_t        state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [2:0]      f3_q, f3_d;
   logic [4:0]      rd_q, rd_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, op_q, op_d, res_q, res_d;

   logic            in_s1, in_s2, neg1, neg2, in_div, in_rem, div_zero, ovf;
   logic [XLEN-1:0] mag1, mag2;

   assign in_s1    = i_f3 inside {OpF3MULH, OpF3MULHSU, OpF3DIV, OpF3REM};
   assign in_s2    = i_f3 inside {OpF3MULH, OpF3DIV, OpF3REM};
   assign neg1     = in_s1 & i_rs1[XLEN-1];
   assign neg2     = in_s2 & i_rs2[XLEN-1];
   assign mag1     = neg1 ? -i_rs1 : i_rs1;
   assign mag2     = neg2 ? -i_rs2 : i_rs2;
   assign in_div   = i_f3 inside {OpF3DIV, OpF3DIVU, OpF3REM, OpF3REMU};
   assign in_rem   = i_f3 inside {OpF3REM, OpF3REMU};
   assign div_zero = in_div && (i_rs2 == '0);
   assign ovf      = (i_f3 inside {OpF3DIV, OpF3REM}) &&
                     (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);

   // hi/lo double as remainder/quotient for divides and product halves for multiplies.
   logic [XLEN-1:0]   step_rem, step_quo;
   rv32_div_step #(.W(XLEN)) u_div_step (
      .rem_i (hi_q),
      .quo_i (lo_q),
      .div_i (op_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   logic [XLEN:0]     madd;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   q_fix, r_fix, calc_res;

   assign madd     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
   assign prod     = {madd, lo_q[XLEN-1:1]};
   assign prod_fix = neg_q ? -prod : prod;
   assign q_fix    = neg_q ? -step_quo : step_quo;
   assign r_fix    = neg_q ? -step_rem : step_rem;

   always_comb begin
      calc_res = '0;
      if (f3_q inside {OpF3REM, OpF3REMU})
         calc_res = r_fix;
      else if (f3_q inside {OpF3DIV, OpF3DIVU})
         calc_res = q_fix;
      else if (f3_q == OpF3MUL)
         calc_res = prod_fix[XLEN-1:0];
      else
         calc_res = prod_fix[2*XLEN-1:XLEN];
   end

`ifdef RV32_MULDIV_FASTMUL_EN
   logic [2*XLEN-1:0] fa, fb, fprod;
   assign fa    = {{XLEN{neg1}}, i_rs1};
   assign fb    = {{XLEN{neg2}}, i_rs2};
   assign fprod = fa * fb;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_d    = op_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (i_valid && !i_flush) begin
               f3_d  = i_f3;
               rd_d  = i_rd;
               cnt_d = '0;
               hi_d  = '0;
               lo_d  = mag1;
               op_d  = mag2;
               neg_d = in_rem ? neg1 : (neg1 ^ neg2);
               if (div_zero) begin
                  res_d   = in_rem ? i_rs1 : '1;
                  state_d = DONE;
               end else if (ovf) begin
                  res_d   = in_rem ? '0 : i_rs1;
                  state_d = DONE;
`ifdef RV32_MULDIV_FASTMUL_EN
               end else if (!in_div) begin
                  res_d   = (i_f3 == OpF3MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
                  state_d = DONE;
`endif
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (f3_q inside {OpF3DIV, OpF3DIVU, OpF3REM, OpF3REMU}) begin
               hi_d = step_rem;
               lo_d = step_quo;
            end else begin
               hi_d = prod[2*XLEN-1:XLEN];
               lo_d = prod[XLEN-1:0];
            end
            if (cnt_q == 5'(MdIterCount - 1)) begin
               res_d   = calc_res;
               state_d = DONE;
            end
         end
         DONE: begin
            if (o_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (i_flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         op_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end

   assign i_ready  = (state_q == IDLE);
   assign o_valid  = (state_q == DONE);
   assign o_busy   = (state_q != IDLE);
   assign o_result = res_q;
   assign o_rd     = rd_q;

endmodule

// File: tb/tb_rv32_muldiv.sv
// Self-checking bench for rv32_muldiv: scoreboard of expected results, per-feature
// tasks. Latency expectations follow RV32_MULDIV_FASTMUL_EN when defined.
module tb_rv32_muldiv;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic [2:0]  i_f3 = '0;
   logic [31:0] i_rs1 = '0;
   logic [31:0] i_rs2 = '0;
   logic [4:0]  i_rd = '0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        o_ready = 1'b0;
   logic [31:0] o_result;
   logic [4:0]  o_rd;
   logic        o_busy;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
   } exp_t;
   exp_t sb[$];

`ifdef RV32_MULDIV_FASTMUL_EN
   localparam int MulLat = 1;
`else
   localparam int MulLat = 33;
`endif
   localparam int IterLat = 33;
   localparam int SpecLat = 1;

   rv32_muldiv dut (
      .clk      (clk),
      .nrst     (nrst),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .i_f3     (i_f3),
      .i_rs1    (i_rs1),
      .i_rs2    (i_rs2),
      .i_rd     (i_rd),
      .i_flush  (i_flush),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o_result (o_result),
      .o_rd     (o_rd),
      .o_busy   (o_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb2, p;
      logic [63:0] ua, ub, up;
      sa  = {{32{a[31]}}, a};
      sb2 = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      case (f3)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin p = sa * sb2; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = sa / sb2; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            p = sa % sb2; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Push expectation, offer the op, wait (bounded) for o_valid, pop and compare.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                         input bit ack, input string name);
      exp_t e;
      int   k;
      bit   got;
      sb.push_back('{res: exp_res, rd: rd, lat: exp_lat});
      @(negedge clk);
      total++;
      if (i_ready !== 1'b1) $display("FAIL %s ready_before_accept: got %b want 1", name, i_ready);
      else passed++;
      i_valid = 1'b1; i_f3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
      @(posedge clk);
      #1 i_valid = 1'b0;
      k = 0; got = 0;
      while (k < 60 && !got) begin
         @(negedge clk);
         k++;
         if (o_valid === 1'b1) got = 1;
      end
      e = sb.pop_front();
      total++;
      if (!got) begin
         $display("FAIL %s timeout: no o_valid within %0d cycles", name, k);
         return;
      end
      passed++;
      total++;
      if (o_result !== e.res) $display("FAIL %s result: got %h want %h", name, o_result, e.res);
      else passed++;
      total++;
      if (o_rd !== e.rd) $display("FAIL %s rd: got %0d want %0d", name, o_rd, e.rd);
      else passed++;
      total++;
      if (k != e.lat) $display("FAIL %s latency: got %0d want %0d", name, k, e.lat);
      else passed++;
      if (ack) begin
         o_ready = 1'b1;
         @(posedge clk);
         #1 o_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'h0 || o_rd !== 5'd0)
         $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b res=%h rd=%0d want 1 0 0 0 0",
                  i_ready, o_valid, o_busy, o_result, o_rd);
      else passed++;
      @(negedge clk);
      nrst = 1'b1;
   endtask

   task automatic test_divu();
      run_op(3'd5, 32'd100, 32'd7, 5'd5, 32'd14, IterLat, 1, "divu_100_7");
      run_op(3'd7, 32'd100, 32'd7, 5'd9, 32'd2, IterLat, 1, "remu_100_7");
   endtask

   task automatic test_div_signed();
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, IterLat, 1, "div_m7_2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, IterLat, 1, "rem_m7_2");
      run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'd1, IterLat, 1, "rem_7_m2");
   endtask

   task automatic test_special();
      run_op(3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, SpecLat, 1, "div_by_zero");
      run_op(3'd6, 32'd5, 32'd0, 5'd11, 32'd5, SpecLat, 1, "rem_by_zero");
      run_op(3'd5, 32'd9, 32'd0, 5'd12, 32'hFFFF_FFFF, SpecLat, 1, "divu_by_zero");
      run_op(3'd7, 32'd9, 32'd0, 5'd13, 32'd9, SpecLat, 1, "remu_by_zero");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, SpecLat, 1, "div_overflow");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0, SpecLat, 1, "rem_overflow");
   endtask

   task automatic test_mul();
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, MulLat, 1, "mulh_min_min");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, MulLat, 1, "mulhu_ones");
      run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001, MulLat, 1, "mul_ones");
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, MulLat, 1, "mulhsu_ones");
      run_op(3'd0, 32'd3, 32'hFFFF_FFFB, 5'd16, 32'hFFFF_FFF1, MulLat, 1, "mul_3_m5");
   endtask

   task automatic test_back_to_back();
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          lat;
      for (int i = 0; i < 12; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 4 == 3) ? 32'h0 : ((i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
         if (f3[2]) lat = (b == 0) ? SpecLat : IterLat;
         else       lat = MulLat;
         run_op(f3, a, b, 5'(i + 17), model(f3, a, b), lat, 1, "random_op");
      end
   endtask

   task automatic test_stall();
      run_op(3'd5, 32'd1000, 32'd3, 5'd21, 32'd333, IterLat, 0, "stall_divu");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (o_valid !== 1'b1 || o_result !== 32'd333 || i_ready !== 1'b0 || o_rd !== 5'd21)
            $display("FAIL stall_hold: got vld=%b res=%0d rdy=%b rd=%0d want 1 333 0 21",
                     o_valid, o_result, i_ready, o_rd);
         else passed++;
      end
      o_ready = 1'b1;
      @(posedge clk);
      #1 o_ready = 1'b0;
      @(negedge clk);
      total++;
      if (i_ready !== 1'b1 || o_valid !== 1'b0)
         $display("FAIL stall_release: got rdy=%b vld=%b want 1 0", i_ready, o_valid);
      else passed++;
   endtask

   task automatic test_flush();
      bit seen;
      @(negedge clk);
      i_valid = 1'b1; i_f3 = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd7; i_rd = 5'd25;
      @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (11) @(negedge clk);
      total++;
      if (o_busy !== 1'b1) $display("FAIL flush_precondition_busy: got %b want 1", o_busy);
      else passed++;
      i_flush = 1'b1;
      @(posedge clk);
      #1 i_flush = 1'b0;
      @(negedge clk);
      total++;
      if (o_busy !== 1'b0 || i_ready !== 1'b1)
         $display("FAIL flush_to_idle: got busy=%b rdy=%b want 0 1", o_busy, i_ready);
      else passed++;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_valid === 1'b1) seen = 1;
      end
      total++;
      if (seen) $display("FAIL flush_no_result: got o_valid pulse want none");
      else passed++;
      // flush coinciding with an accept of a would-be special case
      i_valid = 1'b1; i_flush = 1'b1; i_f3 = 3'd4; i_rs1 = 32'd5; i_rs2 = 32'd0;
      @(posedge clk);
      #1 begin i_valid = 1'b0; i_flush = 1'b0; end
      @(negedge clk);
      total++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0)
         $display("FAIL flush_with_accept: got busy=%b vld=%b want 0 0", o_busy, o_valid);
      else passed++;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      i_valid = 1'b1; i_f3 = 3'd5; i_rs1 = 32'd12345; i_rs2 = 32'd11; i_rd = 5'd17;
      @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (o_busy !== 1'b1 || o_rd !== 5'd17 || o_result === 32'h0)
         $display("FAIL areset_precondition: got busy=%b rd=%0d res=%h want 1 17 nonzero", o_busy, o_rd, o_result);
      else passed++;
      #2 nrst = 1'b0;
      #1;
      total++;
      if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'h0 || o_rd !== 5'd0)
         $display("FAIL areset_outputs: got rdy=%b vld=%b busy=%b res=%h rd=%0d want 1 0 0 0 0",
                  i_ready, o_valid, o_busy, o_result, o_rd);
      else passed++;
      @(negedge clk);
      nrst = 1'b1;
      run_op(3'd5, 32'd50, 32'd5, 5'd2, 32'd10, IterLat, 1, "after_reset");
   endtask

   initial begin
      test_reset();
      test_divu();
      test_div_signed();
      test_special();
      test_mul();
      test_back_to_back();
      test_stall();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rv32_muldiv.md
# rv32_muldiv

Multi-cycle RV32M execute unit: multiply, divide and remainder for register-register ALU instructions with funct7 = 0000001. Sits in the execute stage beside the integer ALU. The decoder forwards funct3, rs1/rs2 values and the rd address whenever an ALU-R op carries the M-extension funct7. Results return over a valid/ready handshake to the writeback mux.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported. Tied to the package register width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  operation offered.
- `i_ready`  out  1  unit can accept; high only in IDLE.
- `i_f3`  in  3  funct3, the M-extension encoding (MUL through REMU).
- `i_rs1`  in  32  dividend / multiplicand.
- `i_rs2`  in  32  divisor / multiplier.
- `i_rd`  in  5  destination register address.
- `i_flush`  in  1  pipeline flush; kills any in-flight op.
- `o_valid`  out  1  result available.
- `o_ready`  in  1  writeback accepts result.
- `o_result`  out  32  result.
- `o_rd`  out  5  destination register address of the result.
- `o_busy`  out  1  state ≠ IDLE; used by hazard logic.

## Operation
- States:
  - IDLE: accept when `i_valid && i_ready`; latch f3 and rd; store |rs1| and |rs2| for signed ops; record the sign fix-up.
    - Special cases go directly to DONE.
    - Everything else goes to CALC with the 5-bit counter at 0.
  - CALC: one iteration per cycle.
    - Divide: restoring shift-subtract.
    - Multiply: shift-add into a 64-bit accumulator.
    - Counter increments each cycle. The cycle with counter = 31 performs the final iteration, applies the sign fix-up and goes to DONE.
  - DONE: `o_valid` = 1; result and rd are held stable. `o_ready` = 1 returns the unit to IDLE.
- Multiply operand handling:
  - MUL, MULH, MULHSU and MULHU extend the operands to 33 bits (signed or unsigned per funct3) and form a 64-bit product.
  - MUL returns [31:0]; the others return [63:32].
- Special cases, all resolved at accept with 1-cycle latency:
  - Divide by zero:
    - DIV and DIVU return 0xFFFFFFFF.
    - REM and REMU return rs1.
  - Signed overflow, rs1 = 0x80000000 and rs2 = 0xFFFFFFFF:
    - DIV returns 0x80000000.
    - REM returns 0.
- Sign rules:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- `i_flush` has priority over everything, in any state, including a simultaneous accept and a pending DONE.
  - Next state is IDLE.
  - `o_valid` drops after that edge.
  - No result is emitted.
- An input presented while not IDLE is ignored; the upstream stage must hold it.

## Timing
- Reset values:
  - state = IDLE.
  - `i_ready` = 1, `o_valid` = 0, `o_busy` = 0.
  - `o_result` = 0, `o_rd` = 0.
  - counter = 0.
- Latency, counted from the accept edge E:
  - Iterative path: `o_valid` high in the cycle after edge E+32 (32 cycles).
  - Special case: `o_valid` high in the cycle after E (1 cycle).
- Output stalls: `o_valid` stays asserted and `o_result` stays stable until `o_ready`. No new accept happens in the cycle `o_ready` is taken; `i_ready` rises the cycle after.
- Throughput: at most 1 op per (latency + 1) cycles.
- Reset asserted mid-operation: immediate return to reset values, independent of `clk`.

## Configuration
- `RV32_MULDIV_FASTMUL_EN`:
  - Defined: multiplies use a single-cycle 33×33 combinational product and go IDLE→DONE with 1-cycle latency. Divides are unchanged.
  - Undefined: multiplies take the 32-cycle iterative path, with no hardware multiplier inferred.

## Structure
- Shared package `rv32_isa` gains:
  - the state enum typedef `MdState_t` (IDLE, CALC, DONE);
  - `MdIterCount` = 32.
- Funct3 decode uses the existing `OpF3MUL`…`OpF3REMU` constants. Funct7 matching uses `OpF7MUL`.
- One combinational sub-module, `rv32_div_step`: a single restoring-divide iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder and quotient.

## Test plan
- DIVU rs1 = 100, rs2 = 7 → 32 cycles later `o_result` = 14; REMU on the same operands → 2; `o_rd` echoes `i_rd`.
- DIV rs1 = -7 (0xFFFFFFF9), rs2 = 2 → 0xFFFFFFFD (-3); REM on the same operands → 0xFFFFFFFF (-1).
- DIV rs1 = 5, rs2 = 0 → 0xFFFFFFFF after 1 cycle; REM → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MUL on the same operands → 0x00000001. Check latency with and without `RV32_MULDIV_FASTMUL_EN`.
- `o_ready` = 0 for 5 cycles in DONE → `o_valid` and `o_result` hold stable and `i_ready` = 0 throughout; `i_flush` at CALC counter 10 → IDLE next cycle and no `o_valid` pulse.
- Assert `nrst` low mid-CALC → outputs return to reset values immediately, without a clock edge.
